// File: rtl/alu_issue_pkg.sv
// Shared widths, instruction field offsets and control states for the ALU instruction issuer.
// Instruction word layout is {sel, rs, rt}, with sel in the MSBs.
package alu_issue_pkg;

    localparam int SELW   = 3;
    localparam int OPW    = 4;
    localparam int DEPTH  = 4;
    localparam int INSTRW = SELW + 2 * OPW;

    localparam int SEL_HI = INSTRW - 1;
    localparam int RS_HI  = 2 * OPW - 1;
    localparam int RT_HI  = OPW - 1;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_RUN,
        ST_STALL,
        ST_DRAIN
    } iss_state_e;

endpackage

// File: rtl/alu_instr_issuer_fifo.sv
// Parameterised synchronous FIFO with flush. Pointers wrap modulo DEPTH.
// The occupancy count is one bit wider than the pointers, so full and empty are never ambiguous.
module instr_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && !full && !flush;
        pop_ok   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/alu_instr_issuer.sv
// Issues queued ALU instructions to a single-cycle execute unit and presents each result with its opcode.
// Pipeline: input FIFO -> ISS register (drives ex_*) -> OUT register (out_rd/out_sel).
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | ISS and OUT both empty
// ST_RUN   | ISS valid, OUT free or draining this cycle
// ST_STALL | ISS valid, OUT valid and held by the consumer
// ST_DRAIN | ISS empty, OUT valid
module alu_instr_issuer
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = alu_issue_pkg::DEPTH,
    parameter int OPW   = alu_issue_pkg::OPW,
    parameter int SELW  = alu_issue_pkg::SELW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW+2*OPW-1:0] in_instr,
    output logic [SELW-1:0]       ex_sel,
    output logic [OPW-1:0]        ex_rs,
    output logic [OPW-1:0]        ex_rt,
    input  logic [OPW-1:0]        ex_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OPW-1:0]        out_rd,
    output logic [SELW-1:0]       out_sel,
    input  logic                  flush
);

    localparam int IW = SELW + 2 * OPW;

    iss_state_e state_q, state_d;

    logic [SELW-1:0] iss_sel_q, iss_sel_d;
    logic [OPW-1:0]  iss_rs_q, iss_rs_d;
    logic [OPW-1:0]  iss_rt_q, iss_rt_d;
    logic            out_valid_q, out_valid_d;
    logic [OPW-1:0]  out_rd_q, out_rd_d;
    logic [SELW-1:0] out_sel_q, out_sel_d;

    logic                 iss_valid, out_free, iss_complete, iss_load;
    logic                 fifo_push;
    logic [IW-1:0]        fifo_rdata;
    logic                 fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                 fifo_count_unused;

    instr_fifo #(
        .WIDTH (IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (iss_load),
        .flush (flush),
        .wdata (in_instr),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The level is exported for observability only.
    assign fifo_count_unused = ^fifo_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (iss_valid && !iss_complete) begin
            state_d = ST_STALL;
        end else if (iss_load) begin
            state_d = ST_RUN;
        end else if (out_valid_d) begin
            state_d = ST_DRAIN;
        end else begin
            state_d = ST_EMPTY;
        end
    end

    // No bypass: a pop while full does not reopen in_ready in the same cycle.
    always_comb begin
        iss_valid    = (state_q == ST_RUN) || (state_q == ST_STALL);
        out_free     = !out_valid_q || out_ready;
        iss_complete = iss_valid && out_free;
        iss_load     = !fifo_empty && (!iss_valid || iss_complete);
        in_ready     = rst_n && !fifo_full && !flush;
        fifo_push    = in_valid && in_ready;

        iss_sel_d = iss_sel_q;
        iss_rs_d  = iss_rs_q;
        iss_rt_d  = iss_rt_q;
        if (iss_load && !flush) begin
            iss_sel_d = fifo_rdata[IW-1 -: SELW];
            iss_rs_d  = fifo_rdata[2*OPW-1 -: OPW];
            iss_rt_d  = fifo_rdata[OPW-1:0];
        end

        out_valid_d = !flush && (iss_complete || (out_valid_q && !out_ready));
        out_rd_d    = out_rd_q;
        out_sel_d   = out_sel_q;
        if (iss_complete && !flush) begin
            out_rd_d  = ex_rd;
            out_sel_d = iss_sel_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_sel_q   <= '0;
            iss_rs_q    <= '0;
            iss_rt_q    <= '0;
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_sel_q   <= '0;
        end else begin
            iss_sel_q   <= iss_sel_d;
            iss_rs_q    <= iss_rs_d;
            iss_rt_q    <= iss_rt_d;
            out_valid_q <= out_valid_d;
            out_rd_q    <= out_rd_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign ex_sel    = iss_sel_q;
    assign ex_rs     = iss_rs_q;
    assign ex_rt     = iss_rt_q;
    assign out_valid = out_valid_q;
    assign out_rd    = out_rd_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_alu_instr_issuer.sv
// Directed bench for alu_instr_issuer with a stub execute unit (sel 2 subtracts, otherwise adds).
module tb_alu_instr_issuer;
    import alu_issue_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [INSTRW-1:0] in_instr = '0;
    logic [SELW-1:0]   ex_sel;
    logic [OPW-1:0]    ex_rs, ex_rt, ex_rd;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OPW-1:0]    out_rd;
    logic [SELW-1:0]   out_sel;
    logic              flush = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [SELW-1:0] st_sel [8] = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2};
    logic [OPW-1:0]  st_rs  [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    logic [OPW-1:0]  st_rt  [8] = '{4'h2, 4'h2, 4'h5, 4'h1, 4'h9, 4'h3, 4'h4, 4'h8};
    logic [OPW-1:0]  st_exp [8] = '{4'h3, 4'h0, 4'h8, 4'h3, 4'hE, 4'h3, 4'hB, 4'h0};
    logic [OPW-1:0]  bp_exp [7] = '{4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD, 4'hF};

    always #5 clk = ~clk;

    assign ex_rd = (ex_sel == 3'd2) ? (ex_rs - ex_rt) : (ex_rs + ex_rt);

    alu_instr_issuer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .ex_sel    (ex_sel),
        .ex_rs     (ex_rs),
        .ex_rt     (ex_rt),
        .ex_rd     (ex_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd    (out_rd),
        .out_sel   (out_sel),
        .flush     (flush)
    );

    function automatic logic [INSTRW-1:0] mk(input logic [SELW-1:0] s, input logic [OPW-1:0] a,
                                             input logic [OPW-1:0] b);
        logic [INSTRW-1:0] w;
        w = '0;
        w[SEL_HI -: SELW] = s;
        w[RS_HI -: OPW]   = a;
        w[RT_HI -: OPW]   = b;
        return w;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        #1 rst_n = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ex", 32'({ex_sel, ex_rs, ex_rt}), 32'd0);
        check("rst_out", 32'({out_sel, out_rd}), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single instruction latency
        in_valid = 1'b1;
        in_instr = mk(3'd1, 4'h3, 4'h5);
        tick();
        in_valid = 1'b0;
        check("lat_n0_out_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_n1_ex", 32'({ex_sel, ex_rs, ex_rt}), 32'({3'd1, 4'h3, 4'h5}));
        check("lat_n1_out_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_n2_out", 32'({out_valid, out_sel, out_rd}), 32'({1'b1, 3'd1, 4'h8}));
        out_ready = 1'b1;
        tick();
        check("lat_drained", 32'(out_valid), 32'd0);

        // Back-to-back stream
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                in_valid = 1'b1;
                in_instr = mk(st_sel[c], st_rs[c], st_rt[c]);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 8) check($sformatf("stream_in_ready_%0d", c), 32'(in_ready), 32'd1);
            tick();
            if (c >= 2)
                check($sformatf("stream_out_%0d", c - 2), 32'({out_valid, out_sel, out_rd}),
                      32'({1'b1, st_sel[c-2], st_exp[c-2]}));
        end
        tick();
        check("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure: fill OUT, ISS and the FIFO
        out_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            in_valid = 1'b1;
            in_instr = mk(3'd1, 4'(j + 1), 4'(j + 2));
            #1;
            check($sformatf("bp_in_ready_%0d", j), 32'(in_ready), 32'd1);
            tick();
        end
        in_instr = mk(3'd1, 4'h7, 4'h8);
        #1;
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("bp_out_held", 32'({out_valid, out_sel, out_rd}), 32'({1'b1, 3'd1, bp_exp[0]}));
        check("bp_ex_stable_a", 32'({ex_rs, ex_rt}), 32'({4'h2, 4'h3}));
        check("bp_still_full", 32'(in_ready), 32'd0);
        tick();
        check("bp_ex_stable_b", 32'({ex_rs, ex_rt}), 32'({4'h2, 4'h3}));
        check("bp_out_held_b", 32'({out_valid, out_sel, out_rd}), 32'({1'b1, 3'd1, bp_exp[0]}));
        out_ready = 1'b1;
        tick();
        check("bp_rel_out_1", 32'({out_valid, out_sel, out_rd}), 32'({1'b1, 3'd1, bp_exp[1]}));
        check("bp_rel_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_rel_out_2", 32'({out_valid, out_sel, out_rd}), 32'({1'b1, 3'd1, bp_exp[2]}));
        for (int r = 3; r < 7; r++) begin
            tick();
            check($sformatf("bp_rel_out_%0d", r), 32'({out_valid, out_sel, out_rd}),
                  32'({1'b1, 3'd1, bp_exp[r]}));
        end
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Result wraps at OPW bits
        in_valid = 1'b1;
        in_instr = mk(3'd1, 4'hF, 4'h2);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("wrap_out", 32'({out_valid, out_sel, out_rd}), 32'({1'b1, 3'd1, 4'h1}));
        tick();

        // Flush with work everywhere and a simultaneous offer
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            in_valid = 1'b1;
            in_instr = mk(3'd1, 4'(j), 4'h1);
            tick();
        end
        check("fl_pre_out_valid", 32'(out_valid), 32'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = mk(3'd3, 4'hC, 4'hC);
        #1;
        check("fl_in_ready_forced", 32'(in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_cleared", 32'(out_valid), 32'd0);
        #1;
        check("fl_in_ready_back", 32'(in_ready), 32'd1);
        tick();
        tick();
        check("fl_nothing_left", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = mk(3'd2, 4'h9, 4'h4);
        tick();
        in_valid = 1'b0;
        tick();
        check("fl_next_ex", 32'({ex_sel, ex_rs, ex_rt}), 32'({3'd2, 4'h9, 4'h4}));
        tick();
        check("fl_next_out", 32'({out_valid, out_sel, out_rd}), 32'({1'b1, 3'd2, 4'h5}));
        tick();

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_instr = mk(3'd1, 4'(j + 2), 4'(j));
            tick();
        end
        in_valid = 1'b0;
        check("mr_pre_out_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd0);
        check("mr_out", 32'({out_sel, out_rd}), 32'd0);
        check("mr_ex", 32'({ex_sel, ex_rs, ex_rt}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mr_post_out_valid", 32'(out_valid), 32'd0);
        check("mr_post_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = mk(3'd1, 4'h6, 4'h7);
        tick();
        in_valid = 1'b0;
        check("mr_acc_n0", 32'(out_valid), 32'd0);
        tick();
        check("mr_acc_n1", 32'(out_valid), 32'd0);
        tick();
        check("mr_acc_n2", 32'({out_valid, out_sel, out_rd}), 32'({1'b1, 3'd1, 4'hD}));
        tick();
        check("mr_drained", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
